// File: rtl/prod_ctrl_pkg.sv
// rtl/prod_ctrl_pkg.sv - state encoding and status LED map for the production controller
package prod_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COMM  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic [3:0] led_of(input state_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/prod_ctrl_lsb_prio_enc.sv
// rtl/prod_ctrl_lsb_prio_enc.sv - lowest-set-bit index encoder with any-bit flag
module lsb_prio_enc #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prod_ctrl.sv
// rtl/prod_ctrl.sv - channel-selecting producer controller with back-pressure gating and drain
module prod_ctrl
    import prod_ctrl_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int DATA_W        = 16,
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int ALLOW_SWITCH  = 0,
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          start,
    input  logic                     stop,
    input  logic                     buf_full,
    input  logic                     buf_empty,
    input  logic                     data_valid_2,
    input  logic [N_CH-1:0]          prod_valid,
    input  logic [N_CH*DATA_W-1:0]   prod_data,
    output logic [N_CH-1:0]          prod_en,
    output logic [DATA_W-1:0]        data_1,
    output logic                     data_1_en,
    output logic [CH_W:0]            modulo,
    output logic [3:0]               led,
    output logic [CNT_W-1:0]         word_cnt,
    output logic                     drain_to
);

    localparam int DC_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam int TO_LAST = (DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1;

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [DC_W-1:0]   drain_cnt;
    logic [N_CH-1:0]   ch_oh;
    logic [CH_W-1:0]   start_idx;
    logic              start_any;
    logic [CH_W-1:0]   sw_idx;
    logic              sw_any;
    logic              drain_expired;

    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_oh[i] = (CH_W'(i) == ch);
        end
    end

    lsb_prio_enc #(.N(N_CH), .W(CH_W)) u_start_enc (
        .vec (start),
        .idx (start_idx),
        .any (start_any)
    );

    // Only starts naming a channel other than the active one can cause a switch.
    lsb_prio_enc #(.N(N_CH), .W(CH_W)) u_switch_enc (
        .vec (start & ~ch_oh),
        .idx (sw_idx),
        .any (sw_any)
    );

    assign drain_expired = (DRAIN_TIMEOUT != 0) && (drain_cnt == DC_W'(TO_LAST));

    assign prod_en   = (state == S_COMM && !buf_full) ? ch_oh : '0;
    assign data_1    = (state == S_COMM) ? prod_data[int'(ch)*DATA_W +: DATA_W] : '0;
    assign data_1_en = (state == S_COMM) && !buf_full && prod_valid[ch];
    assign modulo    = (state == S_COMM || state == S_WAIT) ? ({1'b0, ch} + (CH_W+1)'(1)) : '0;
    assign led       = led_of(state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ch        <= '0;
            word_cnt  <= '0;
            drain_to  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (data_1_en && word_cnt != '1) begin
                word_cnt <= word_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_any) begin
                        state    <= S_COMM;
                        ch       <= start_idx;
                        word_cnt <= '0;
                        drain_to <= 1'b0;
                    end
                end
                S_COMM, S_WAIT: begin
                    if (stop) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else if (state == S_COMM && buf_full) begin
                        state <= S_WAIT;
                    end else if (state == S_WAIT && !buf_full) begin
                        state <= S_COMM;
                    end else if (ALLOW_SWITCH != 0 && sw_any) begin
                        ch <= sw_idx;
                    end
                end
                S_DRAIN: begin
                    if (buf_empty && !data_valid_2) begin
                        state <= S_IDLE;
                    end else if (drain_expired) begin
                        state    <= S_IDLE;
                        drain_to <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_ctrl.sv
// tb/tb_prod_ctrl.sv - scoreboard bench for prod_ctrl with a behavioural session model
module tb_prod_ctrl;

    localparam int NCH = 3;
    localparam int DW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  start = '0;
    logic            stop = 1'b0;
    logic            buf_full = 1'b0;
    logic            buf_empty = 1'b0;
    logic            data_valid_2 = 1'b0;
    logic [NCH-1:0]  prod_valid = '0;
    logic [NCH*DW-1:0] prod_data = '0;
    logic [NCH-1:0]  prod_en;
    logic [DW-1:0]   data_1;
    logic            data_1_en;
    logic [2:0]      modulo;
    logic [3:0]      led;
    logic [3:0]      word_cnt;
    logic            drain_to;

    prod_ctrl #(
        .N_CH(NCH), .DATA_W(DW), .CNT_W(4), .DRAIN_TIMEOUT(8), .ALLOW_SWITCH(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .buf_full(buf_full),
        .buf_empty(buf_empty), .data_valid_2(data_valid_2), .prod_valid(prod_valid),
        .prod_data(prod_data), .prod_en(prod_en), .data_1(data_1), .data_1_en(data_1_en),
        .modulo(modulo), .led(led), .word_cnt(word_cnt), .drain_to(drain_to)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] en;
        logic [7:0] d;
        logic       we;
        logic [2:0] md;
        logic [3:0] ld;
        logic [3:0] cnt;
        logic       to;
    } exp_t;

    exp_t       eq[$];
    logic [7:0] wq[$];
    int total = 0;
    int bad = 0;

    // Session model: 0 idle, 1 producing, 2 waiting on full buffer, 3 draining
    int m_state = 0, m_ch = 0, m_cnt = 0, m_dcnt = 0;
    bit m_to = 0;

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic int lowest(input logic [NCH-1:0] v, input int excl);
        for (int i = 0; i < NCH; i++) if (v[i] && i != excl) return i;
        return -1;
    endfunction

    task automatic cycle(input logic [NCH-1:0] st, input logic sp, input logic fl,
                         input logic em, input logic dv, input logic [NCH-1:0] pv);
        exp_t e;
        int j;
        start = st; stop = sp; buf_full = fl; buf_empty = em; data_valid_2 = dv;
        prod_valid = pv; prod_data = 24'($urandom);
        e.en  = (m_state == 1 && !fl) ? 3'(1 << m_ch) : 3'd0;
        e.d   = (m_state == 1) ? prod_data[m_ch*DW +: DW] : 8'd0;
        e.we  = (m_state == 1) && !fl && pv[m_ch];
        e.md  = (m_state == 1 || m_state == 2) ? 3'(m_ch + 1) : 3'd0;
        e.ld  = 4'(1 << m_state);
        e.cnt = 4'(m_cnt);
        e.to  = m_to;
        eq.push_back(e);
        if (e.we) begin
            wq.push_back(e.d);
            if (m_cnt < 15) m_cnt++;
        end
        case (m_state)
            0: if (st != 0) begin
                m_state = 1; m_ch = lowest(st, -1); m_cnt = 0; m_to = 0;
            end
            1, 2: begin
                j = lowest(st, m_ch);
                if (sp) begin m_state = 3; m_dcnt = 0; end
                else if (m_state == 1 && fl) m_state = 2;
                else if (m_state == 2 && !fl) m_state = 1;
                else if (j >= 0) m_ch = j;
            end
            default: begin
                if (em && !dv) m_state = 0;
                else if (m_dcnt == 7) begin m_state = 0; m_to = 1; end
                else m_dcnt++;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && eq.size() > 0) begin
            exp_t e;
            e = eq.pop_front();
            chk("prod_en", prod_en, e.en);
            chk("data_1", data_1, e.d);
            chk("data_1_en", data_1_en, e.we);
            chk("modulo", modulo, e.md);
            chk("led", led, e.ld);
            chk("word_cnt", word_cnt, e.cnt);
            chk("drain_to", drain_to, e.to);
            if (data_1_en) begin
                if (wq.size() == 0) chk("write_unexpected", 1, 0);
                else chk("write_word", data_1, wq.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 4'b0001);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_drain_to", drain_to, 0);
        chk("rst_prod_en", prod_en, 0);
        rst = 1'b1;

        // channel 1 session, five words
        cycle(3'b010, 0, 0, 0, 0, 3'b000);
        chk("t1_modulo", modulo, 2);
        chk("t1_prod_en", prod_en, 3'b010);
        repeat (5) cycle(3'b000, 0, 0, 0, 0, 3'b010);
        chk("t1_word_cnt", word_cnt, 5);
        // back-pressure into WAIT and back
        cycle(3'b000, 0, 1, 0, 0, 3'b111);
        cycle(3'b000, 0, 1, 0, 0, 3'b111);
        chk("t2_led_wait", led, 4'b0100);
        chk("t2_prod_en", prod_en, 0);
        cycle(3'b000, 0, 0, 0, 0, 3'b111);
        cycle(3'b000, 0, 0, 0, 0, 3'b111);
        // stop from WAIT, hold DRAIN while consumer still busy
        cycle(3'b000, 0, 1, 0, 0, 3'b111);
        cycle(3'b000, 1, 1, 0, 0, 3'b000);
        repeat (3) cycle(3'b000, 0, 0, 1, 1, 3'b000);
        cycle(3'b000, 0, 0, 1, 0, 3'b000);
        chk("t3_led_idle", led, 4'b0001);
        // drain timeout
        cycle(3'b001, 0, 0, 0, 0, 3'b000);
        cycle(3'b000, 1, 0, 0, 0, 3'b001);
        repeat (8) cycle(3'b000, 0, 0, 0, 1, 3'b000);
        chk("t4_led_idle", led, 4'b0001);
        chk("t4_drain_to", drain_to, 1);
        // channel switch keeps the count
        cycle(3'b001, 0, 0, 0, 0, 3'b000);
        repeat (3) cycle(3'b000, 0, 0, 0, 0, 3'b111);
        cycle(3'b110, 0, 0, 0, 0, 3'b000);
        chk("t5_modulo", modulo, 2);
        chk("t5_word_cnt", word_cnt, 3);
        cycle(3'b000, 1, 0, 0, 0, 3'b111);
        cycle(3'b000, 0, 0, 1, 0, 3'b000);
        // start and stop together in IDLE, then reset mid-session
        cycle(3'b011, 1, 0, 0, 0, 3'b000);
        chk("t6_led_comm", led, 4'b0010);
        chk("t6_modulo", modulo, 1);
        cycle(3'b000, 0, 0, 0, 0, 3'b001);
        rst = 1'b0;
        #1;
        chk("t6_rst_led", led, 4'b0001);
        chk("t6_rst_prod_en", prod_en, 0);
        chk("t6_rst_data_1_en", data_1_en, 0);
        m_state = 0; m_ch = 0; m_cnt = 0; m_dcnt = 0; m_to = 0;
        wq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] st;
            st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cycle(st, $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom));
        end
        @(negedge clk);
        #1;
        chk("eq_drained", eq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
